// File: rtl/sd_spi_shifter_if.sv
// CPU-side register bus for the SD-card SPI shifter: select, strobes, address and data.
interface sd_spi_shifter_if;
    logic       adr;
    logic       cs;
    logic       we;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (
        output adr,
        output cs,
        output we,
        output rd,
        output din,
        input  dout
    );

    modport slave (
        input  adr,
        input  cs,
        input  we,
        input  rd,
        input  din,
        output dout
    );
endinterface

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 byte shifter for an SD card: data register at adr=0, control/status at adr=1,
// selectable slow/fast SCK divisor latched per transfer.
module sd_spi_shifter #(
    parameter int unsigned DIV_SLOW = 35,
    parameter int unsigned DIV_FAST = 1
) (
    input  logic              clk,
    input  logic              reset,
    sd_spi_shifter_if.slave   bus,
    input  logic              sd_dat,
    output logic              sd_clk,
    output logic              sd_cmd,
    output logic              sd_res
);

    localparam logic [5:0] DIV_SLOW_W = 6'(DIV_SLOW);
    localparam logic [5:0] DIV_FAST_W = 6'(DIV_FAST);

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t     state_q, state_d;
    logic       done_q, done_d;
    logic       speed_q, speed_d;
    logic       sd_res_q, sd_res_d;
    logic       sd_clk_q, sd_clk_d;
    logic       sd_cmd_q, sd_cmd_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [5:0] phase_q, phase_d;
    logic [5:0] div_q, div_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] data_q, data_d;

    logic       busy;
    logic       data_wr;
    logic       ctrl_wr;
    logic       data_rd;

    assign busy    = (state_q == ST_BUSY);
    assign data_wr = bus.cs & bus.we & ~bus.adr;
    assign ctrl_wr = bus.cs & bus.we & bus.adr;
    assign data_rd = bus.cs & bus.rd & ~bus.adr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            speed_q   <= 1'b0;
            sd_res_q  <= 1'b1;
            sd_clk_q  <= 1'b0;
            sd_cmd_q  <= 1'b1;
            bit_cnt_q <= '0;
            phase_q   <= '0;
            div_q     <= DIV_SLOW_W;
            tx_q      <= '1;
            rx_q      <= '1;
            data_q    <= '1;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            speed_q   <= speed_d;
            sd_res_q  <= sd_res_d;
            sd_clk_q  <= sd_clk_d;
            sd_cmd_q  <= sd_cmd_d;
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        speed_d   = speed_q;
        sd_res_d  = sd_res_q;
        sd_clk_d  = sd_clk_q;
        sd_cmd_d  = sd_cmd_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        div_d     = div_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        data_d    = data_q;

        if (ctrl_wr) begin
            sd_res_d = ~bus.din[0];
            speed_d  = bus.din[1];
        end

        // Read-clear comes first so a completion in the same cycle leaves done set.
        if (data_rd) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (data_wr) begin
                    state_d   = ST_BUSY;
                    tx_d      = bus.din;
                    done_d    = 1'b0;
                    bit_cnt_d = '0;
                    sd_cmd_d  = bus.din[7];
                    phase_d   = '0;
                    div_d     = speed_q ? DIV_FAST_W : DIV_SLOW_W;
                end
            end
            ST_BUSY: begin
                if (phase_q == div_q) begin
                    phase_d  = '0;
                    sd_clk_d = ~sd_clk_q;
                    if (!sd_clk_q) begin
                        rx_d = {rx_q[6:0], sd_dat};
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d  = ST_IDLE;
                            done_d   = 1'b1;
                            data_d   = rx_q;
                            sd_cmd_d = 1'b1;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b1};
                            sd_cmd_d = tx_q[6];
                        end
                    end
                end else begin
                    phase_d = phase_q + 6'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        if (bus.adr) begin
            bus.dout = {busy, done_q, 4'b0000, speed_q, ~sd_res_q};
        end else begin
            bus.dout = data_q;
        end
    end

    assign sd_clk = sd_clk_q;
    assign sd_cmd = sd_cmd_q;
    assign sd_res = sd_res_q;

endmodule

// File: tb/tb_sd_spi_shifter.sv
// Directed bench for sd_spi_shifter: scoreboard queues of expected MOSI bits and receive bytes,
// a MISO card model keyed to SCK rises, and an SCK edge logger for timing checks.
module tb_sd_spi_shifter;

    localparam int DIV_SLOW = 35;
    localparam int DIV_FAST = 1;

    logic clk = 1'b0;
    logic reset;
    logic sd_dat;
    logic sd_clk;
    logic sd_cmd;
    logic sd_res;

    sd_spi_shifter_if bus_if ();

    sd_spi_shifter #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .sd_dat (sd_dat),
        .sd_clk (sd_clk),
        .sd_cmd (sd_cmd),
        .sd_res (sd_res)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // SCK edge logger, sampled on the falling clk edge.
    int   sck_edges = 0;
    int   rise_cnt  = 0;
    int   edge_cyc [256];
    logic mosi_log [256];
    logic prev_sck = 1'b0;

    always @(negedge clk) begin
        if (sd_clk !== prev_sck) begin
            if (sck_edges < 256) edge_cyc[sck_edges] <= cyc_cnt;
            sck_edges <= sck_edges + 1;
            if (sd_clk === 1'b1) begin
                if (rise_cnt < 256) mosi_log[rise_cnt] <= sd_cmd;
                rise_cnt <= rise_cnt + 1;
            end
        end
        prev_sck <= sd_clk;
    end

    // Card model: presents bit (7 - rises since load) of miso_byte.
    logic [7:0] miso_byte = 8'hFF;
    int         miso_base = 0;
    logic [2:0] miso_idx;

    always_comb begin
        miso_idx = 3'(rise_cnt - miso_base);
        sd_dat   = miso_byte[3'd7 - miso_idx];
    end

    logic [7:0] exp_data_q [$];
    logic       exp_mosi_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        bus_if.cs  = 1'b1;
        bus_if.we  = 1'b1;
        bus_if.adr = a;
        bus_if.din = d;
        tick();
        bus_if.cs  = 1'b0;
        bus_if.we  = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] v);
        bus_if.adr = 1'b1;
        #1;
        v = bus_if.dout;
    endtask

    task automatic read_data(output logic [7:0] v);
        bus_if.adr = 1'b0;
        bus_if.cs  = 1'b1;
        bus_if.rd  = 1'b1;
        #1;
        v = bus_if.dout;
        tick();
        bus_if.cs  = 1'b0;
        bus_if.rd  = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic [7:0] rx,
                              output int acc, output int r0, output int e0);
        miso_byte = rx;
        miso_base = rise_cnt;
        r0 = rise_cnt;
        e0 = sck_edges;
        for (int i = 7; i >= 0; i--) exp_mosi_q.push_back(tx[i]);
        exp_data_q.push_back(rx);
        bus_write(1'b0, tx);
        acc = cyc_cnt;
    endtask

    task automatic wait_idle(input int budget, output int clr);
        logic [7:0] s;
        clr = -1;
        for (int i = 0; i < budget; i++) begin
            read_status(s);
            if (s[7] == 1'b0) begin
                clr = cyc_cnt;
                break;
            end
            tick();
        end
    endtask

    task automatic check_mosi(input string tag, input int r0);
        logic [7:0] ob;
        logic [7:0] eb;
        for (int i = 0; i < 8; i++) begin
            eb[7-i] = exp_mosi_q.pop_front();
            ob[7-i] = mosi_log[r0+i];
        end
        check(tag, 32'(ob), 32'(eb));
    endtask

    task automatic check_spacing(input string tag, input int e0, input int half);
        int bad;
        bad = 0;
        for (int k = 1; k < 16; k++) begin
            if (edge_cyc[e0+k] - edge_cyc[e0+k-1] != half) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic check_data(input string tag);
        logic [7:0] v;
        logic [7:0] e;
        read_data(v);
        e = exp_data_q.pop_front();
        check(tag, 32'(v), 32'(e));
    endtask

    initial begin
        logic [7:0] s;
        int acc, r0, e0, clr, e_after;

        bus_if.cs  = 1'b0;
        bus_if.we  = 1'b0;
        bus_if.rd  = 1'b0;
        bus_if.adr = 1'b0;
        bus_if.din = 8'h00;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        read_status(s);
        check("rst_status", 32'(s), 32'h00);
        check("rst_sd_cmd", 32'(sd_cmd), 32'd1);
        check("rst_sd_res", 32'(sd_res), 32'd1);
        check("rst_sd_clk", 32'(sd_clk), 32'd0);
        exp_data_q.push_back(8'hFF);
        check_data("rst_data");

        // Fast transfer A5 out, 3C in
        bus_write(1'b1, 8'h03);
        check("sel_sd_res", 32'(sd_res), 32'd0);
        read_status(s);
        check("ctrl_status", 32'(s), 32'h03);
        start_xfer(8'hA5, 8'h3C, acc, r0, e0);
        read_status(s);
        check("busy_status", 32'(s), 32'h83);
        wait_idle(200, clr);
        check("fast_busy_lat", clr - acc, 16 * (DIV_FAST + 1));
        tick();
        check("fast_edges", sck_edges - e0, 16);
        check("fast_first_rise", edge_cyc[e0] - acc, DIV_FAST + 1);
        check_spacing("fast_half", e0, DIV_FAST + 1);
        check_mosi("fast_mosi", r0);
        check("idle_sd_cmd", 32'(sd_cmd), 32'd1);
        read_status(s);
        check("done_status", 32'(s), 32'h43);
        check_data("fast_data");
        read_status(s);
        check("done_cleared", 32'(s), 32'h03);

        // Slow transfer FF out, 5A in
        bus_write(1'b1, 8'h01);
        start_xfer(8'hFF, 8'h5A, acc, r0, e0);
        wait_idle(2000, clr);
        check("slow_busy_lat", clr - acc, 16 * (DIV_SLOW + 1));
        tick();
        check("slow_edges", sck_edges - e0, 16);
        check("slow_first_rise", edge_cyc[e0] - acc, DIV_SLOW + 1);
        check_spacing("slow_half", e0, DIV_SLOW + 1);
        check_mosi("slow_mosi", r0);
        check_data("slow_data");

        // Write while busy is ignored
        bus_write(1'b1, 8'h03);
        start_xfer(8'hA5, 8'hC3, acc, r0, e0);
        repeat (5) tick();
        bus_write(1'b0, 8'h12);
        wait_idle(200, clr);
        check("ign_busy_lat", clr - acc, 16 * (DIV_FAST + 1));
        tick();
        check_mosi("ign_mosi", r0);
        e_after = sck_edges;
        repeat (60) tick();
        check("ign_no_extra", sck_edges - e_after, 0);
        check("ign_edges", sck_edges - e0, 16);
        check_data("ign_data");

        // Control write mid-transfer: deselect and slow speed
        start_xfer(8'h96, 8'h69, acc, r0, e0);
        repeat (9) tick();
        bus_write(1'b1, 8'h00);
        check("mid_sd_res", 32'(sd_res), 32'd1);
        read_status(s);
        check("mid_status", 32'(s), 32'h80);
        wait_idle(200, clr);
        check("mid_busy_lat", clr - acc, 16 * (DIV_FAST + 1));
        tick();
        check_spacing("mid_half", e0, DIV_FAST + 1);
        check_mosi("mid_mosi", r0);
        check_data("mid_data");
        start_xfer(8'hF0, 8'h0F, acc, r0, e0);
        wait_idle(2000, clr);
        check("next_busy_lat", clr - acc, 16 * (DIV_SLOW + 1));
        tick();
        check("next_first_rise", edge_cyc[e0] - acc, DIV_SLOW + 1);
        check_spacing("next_half", e0, DIV_SLOW + 1);
        check_mosi("next_mosi", r0);
        check_data("next_data");

        // Reset during bit 4
        bus_write(1'b1, 8'h03);
        start_xfer(8'h5A, 8'hA5, acc, r0, e0);
        for (int i = 0; i < 100; i++) begin
            if (rise_cnt - r0 >= 4) break;
            tick();
        end
        check("abort_rises", rise_cnt - r0, 4);
        reset = 1'b1;
        #1;
        check("abort_sd_clk", 32'(sd_clk), 32'd0);
        check("abort_sd_cmd", 32'(sd_cmd), 32'd1);
        check("abort_sd_res", 32'(sd_res), 32'd1);
        exp_mosi_q.delete();
        void'(exp_data_q.pop_back());
        exp_data_q.push_back(8'hFF);
        tick();
        reset = 1'b0;
        tick();
        e_after = sck_edges;
        read_status(s);
        check("abort_status", 32'(s), 32'h00);
        check_data("abort_data");
        repeat (60) tick();
        check("abort_no_edges", sck_edges - e_after, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
